tag_ram_ctrl: RTL and testbench

Write-port sequencer and arbiter for one cache tag RAM bank (dual-port: port A write, port B registered read, 1-cycle read latency, read-first on same-address collision). Clears every entry after reset and on flush, arbitrates refill and invalidate writes onto port A, and passes lookups through port B with optional same-cycle write forwarding. Sits between the cache FSM / CACHE-instruction logic and the tag RAM instance of each way.

---
 rtl/tag_ram_ctrl.sv | 140 ++++++++++++++
 tb/tb_tag_ram_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ram_ctrl.sv
// Port-A write sequencer/arbiter and port-B lookup path for one cache tag RAM bank.
// Optional macro TAG_BYPASS_EN forwards same-cycle write data to colliding lookups.
module tag_ram_ctrl #(
  parameter int LEN_DATA = 20,
  parameter int LEN_ADDR = 10
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                refill_req,
  input  logic [LEN_ADDR-1:0] refill_addr,
  input  logic [LEN_DATA-1:0] refill_data,
  output logic                refill_ack,
  input  logic                inv_req,
  input  logic [LEN_ADDR-1:0] inv_addr,
  output logic                inv_ack,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_done,
  input  logic                lk_en,
  input  logic [LEN_ADDR-1:0] lk_addr,
  output logic [LEN_DATA-1:0] lk_data,
  output logic                lk_stall,
  output logic                ram_ena,
  output logic                ram_wea,
  output logic [LEN_ADDR-1:0] ram_addra,
  output logic [LEN_DATA-1:0] ram_dina,
  output logic                ram_enb,
  output logic [LEN_ADDR-1:0] ram_addrb,
  input  logic [LEN_DATA-1:0] ram_doutb,
  output logic [1:0]          dbg_state_o
);

  // Handshake: refill/inv requests are held high until their ack, which is
  // combinational and coincides with the port-A write; lookups are fire-and-forget
  // with data one cycle later, reissued by the requester when lk_stall is high.

  typedef enum logic [1:0] {S_INIT = 2'd0, S_IDLE = 2'd1, S_FLUSH = 2'd2} state_e;

  state_e              state_q;
  logic [LEN_ADDR-1:0] cnt_q;
  logic                flush_done_q;
  logic                lk_ok_q;

  logic                wr_en;
  logic [LEN_ADDR-1:0] wr_addr;
  logic [LEN_DATA-1:0] wr_data;
  logic                collision;

  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = cnt_q;
    wr_data    = '0;
    refill_ack = 1'b0;
    inv_ack    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_INIT, S_FLUSH: wr_en = 1'b1;
        S_IDLE: begin
          if (refill_req) begin
            wr_en      = 1'b1;
            wr_addr    = refill_addr;
            wr_data    = refill_data;
            refill_ack = 1'b1;
          end else if (inv_req) begin
            wr_en   = 1'b1;
            wr_addr = inv_addr;
            inv_ack = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_ena     = wr_en;
  assign ram_wea     = wr_en;
  assign ram_addra   = wr_addr;
  assign ram_dina    = wr_data;
  assign ram_enb     = lk_en;
  assign ram_addrb   = lk_addr;
  assign ready       = !rst && (state_q == S_IDLE);
  assign flush_busy  = !rst && (state_q == S_FLUSH);
  assign flush_done  = flush_done_q;
  assign dbg_state_o = state_q;

  // Sweep-write collisions need no handling: those lookups already read as a miss.
  assign collision = lk_en && wr_en && (state_q == S_IDLE) && (wr_addr == lk_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      lk_ok_q      <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      lk_ok_q      <= lk_en && (state_q == S_IDLE);
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= S_IDLE;
        end
        S_FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q      <= S_IDLE;
            flush_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!refill_req && !inv_req && flush_req) state_q <= S_FLUSH;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef TAG_BYPASS_EN
  logic                coll_q;
  logic [LEN_DATA-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      coll_q     <= collision;
      byp_data_q <= wr_data;
    end
  end

  assign lk_stall = 1'b0;
  assign lk_data  = !lk_ok_q ? '0 : (coll_q ? byp_data_q : ram_doutb);
`else
  assign lk_stall = collision;
  assign lk_data  = lk_ok_q ? ram_doutb : '0;
`endif

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed + randomized bench for tag_ram_ctrl with a behavioural tag RAM and array model.
module tb_tag_ram_ctrl;
  localparam int LD    = 8;
  localparam int LA    = 4;
  localparam int DEPTH = 16;
`ifdef TAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst;
  logic          ready, refill_req, refill_ack, inv_req, inv_ack;
  logic          flush_req, flush_busy, flush_done;
  logic [LA-1:0] refill_addr, inv_addr, lk_addr, ram_addra, ram_addrb;
  logic [LD-1:0] refill_data, lk_data, ram_dina, ram_doutb;
  logic          lk_en, lk_stall, ram_ena, ram_wea, ram_enb;
  logic [1:0]    dbg_state;

  logic [LD-1:0] mem [DEPTH];
  logic [LD-1:0] ref_mem [DEPTH];
  int tests = 0;
  int fails = 0;

  tag_ram_ctrl #(.LEN_DATA(LD), .LEN_ADDR(LA)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_data(refill_data),
    .refill_ack(refill_ack), .inv_req(inv_req), .inv_addr(inv_addr), .inv_ack(inv_ack),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .lk_en(lk_en), .lk_addr(lk_addr), .lk_data(lk_data), .lk_stall(lk_stall),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port read-first tag RAM
  initial begin
    ram_doutb = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = LD'($urandom_range(1, 255));
  end
  always @(posedge clk) begin
    if (ram_enb) ram_doutb <= mem[ram_addrb];
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [LA-1:0] a);
    lk_en = 1'b1;
    lk_addr = a;
    #1;
    chk("lk_nostall", 32'(lk_stall), 32'd0);
    tick();
    lk_en = 1'b0;
    chk($sformatf("lk_data[%0d]", a), 32'(lk_data), 32'(ref_mem[a]));
  endtask

  initial begin
    logic [1:0]    op;
    logic [LA-1:0] ra, ia, la, w_addr;
    logic [LD-1:0] rd, w_data, exp_rd;
    logic          le, has_w, coll;

    rst = 1'b1; refill_req = 0; inv_req = 0; flush_req = 0; lk_en = 0;
    refill_addr = '0; refill_data = '0; inv_addr = '0; lk_addr = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_refill_ack", 32'(refill_ack), 0);
    chk("rst_inv_ack", 32'(inv_ack), 0);
    chk("rst_flush_busy", 32'(flush_busy), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    chk("rst_lk_stall", 32'(lk_stall), 0);
    chk("rst_lk_data", 32'(lk_data), 0);
    chk("rst_wea", 32'(ram_wea), 0);

    // Initial clear sweep
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("init_wea", 32'(ram_wea), 1);
      chk("init_addr", 32'(ram_addra), 32'(i));
      chk("init_din", 32'(ram_dina), 0);
      chk("init_ready", 32'(ready), 0);
      tick();
    end
    chk("init_ready_after", 32'(ready), 1);
    chk("init_no_done", 32'(flush_done), 0);
    lookup(4'd5);

    // Refill beats invalidate, invalidate follows
    refill_req = 1; refill_addr = 3; refill_data = 8'hA5;
    inv_req = 1; inv_addr = 7;
    #1;
    chk("prio_refill_ack", 32'(refill_ack), 1);
    chk("prio_inv_wait", 32'(inv_ack), 0);
    chk("prio_addr", 32'(ram_addra), 3);
    tick();
    refill_req = 0; ref_mem[3] = 8'hA5;
    #1;
    chk("prio_inv_ack", 32'(inv_ack), 1);
    chk("prio_inv_din", 32'(ram_dina), 0);
    chk("prio_inv_addr", 32'(ram_addra), 7);
    tick();
    inv_req = 0; ref_mem[7] = 8'h00;
    lookup(4'd3);
    lookup(4'd7);

    // Same-cycle collision
    refill_req = 1; refill_addr = 9; refill_data = 8'h3C;
    lk_en = 1; lk_addr = 9;
    #1;
    chk("coll_stall", 32'(lk_stall), BYP ? 0 : 1);
    tick();
    refill_req = 0; lk_en = 0; ref_mem[9] = 8'h3C;
    if (BYP) chk("coll_bypass", 32'(lk_data), 32'h3C);
    else lookup(4'd9);

    // Randomized refill / invalidate / lookup traffic
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      ra = LA'($urandom_range(0, DEPTH - 1));
      ia = LA'($urandom_range(0, DEPTH - 1));
      rd = LD'($urandom_range(0, 255));
      le = 1'($urandom_range(0, 1));
      has_w  = (op != 2'd0);
      w_addr = op[0] ? ra : ia;
      w_data = op[0] ? rd : '0;
      la = ($urandom_range(0, 2) == 0) ? w_addr : LA'($urandom_range(0, DEPTH - 1));
      coll   = le && has_w && (la == w_addr);
      exp_rd = coll ? w_data : ref_mem[la];
      refill_req = op[0]; refill_addr = ra; refill_data = rd;
      inv_req = op[1]; inv_addr = ia;
      lk_en = le; lk_addr = la;
      #1;
      chk("rnd_refill_ack", 32'(refill_ack), 32'(op[0]));
      chk("rnd_inv_ack", 32'(inv_ack), 32'(op == 2'd2));
      chk("rnd_stall", 32'(lk_stall), 32'(coll && !BYP));
      tick();
      refill_req = 0; inv_req = 0; lk_en = 0;
      if (has_w) ref_mem[w_addr] = w_data;
      if (le && !(coll && !BYP)) chk("rnd_lk_data", 32'(lk_data), 32'(exp_rd));
    end

    // Fill everything then flush with a refill waiting
    for (int i = 0; i < DEPTH; i++) begin
      refill_req = 1; refill_addr = LA'(i); refill_data = 8'hFF;
      #1;
      tick();
      ref_mem[i] = 8'hFF;
    end
    refill_req = 0;
    flush_req = 1;
    #1;
    chk("flush_accept_nowrite", 32'(ram_wea), 0);
    tick();
    flush_req = 0;
    refill_req = 1; refill_addr = 2; refill_data = 8'h5A;
    for (int i = 0; i < DEPTH; i++) begin
      lk_en = (i == 4); lk_addr = 10;
      #1;
      chk("flush_busy", 32'(flush_busy), 1);
      chk("flush_no_ack", 32'(refill_ack), 0);
      chk("flush_not_ready", 32'(ready), 0);
      chk("flush_no_done", 32'(flush_done), 0);
      tick();
      lk_en = 0;
      if (i == 4) chk("flush_lk_miss", 32'(lk_data), 0);
    end
    chk("flush_done", 32'(flush_done), 1);
    chk("flush_ready", 32'(ready), 1);
    chk("flush_busy_off", 32'(flush_busy), 0);
    chk("flush_refill_ack", 32'(refill_ack), 1);
    tick();
    refill_req = 0;
    #1;
    chk("flush_done_pulse", 32'(flush_done), 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_mem[2] = 8'h5A;
    for (int i = 0; i < DEPTH; i++) lookup(LA'(i));

    // Reset in the middle of a flush
    flush_req = 1;
    #1;
    tick();
    flush_req = 0;
    repeat (7) tick();
    chk("midflush_busy", 32'(flush_busy), 1);
    rst = 1;
    #1;
    chk("midflush_rst_wea", 32'(ram_wea), 0);
    tick();
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("reinit_addr", 32'(ram_addra), 32'(i));
      chk("reinit_wea", 32'(ram_wea), 1);
      chk("reinit_ready", 32'(ready), 0);
      chk("reinit_no_done", 32'(flush_done), 0);
      tick();
    end
    chk("reinit_ready_after", 32'(ready), 1);
    chk("reinit_no_done_after", 32'(flush_done), 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    lookup(4'd2);
    lookup(4'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
